shared_reg_arb: RTL and testbench
=================================

SHARED_REG_ARB -- requirements
Module: shared_reg_arb

Interface
REQ-001 Parameter: HOLD_CYC, default 2, cycles the register is held stable after each update (legal range 1..15).
REQ-002 Parameter: CNT_W, default 8, width of the per-port write counters.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 resetn  input  1  reset, asynchronous, active-high.
REQ-005 req0_valid  input  1  port 0 write request.
REQ-006 req0_data  input  9  port 0 write data.
REQ-007 req0_ready  output  1  port 0 transfer accepted this cycle when high together with req0_valid.
REQ-008 req1_valid  input  1  port 1 write request.
REQ-009 req1_data  input  32  port 1 write data.
REQ-010 req1_ready  output  1  port 1 transfer accepted this cycle when high together with req1_valid.
REQ-011 reg_q  output  32  shared register contents.
REQ-012 reg_src  output  1  port index of the last write into reg_q.
REQ-013 reg_upd  output  1  one-cycle pulse in the cycle after reg_q changes.
REQ-014 busy  output  1  high while in HOLD.
REQ-015 wr_cnt0, wr_cnt1  output  CNT_W each  accepted-write counts for port 0 and port 1.

Function
REQ-016 Two-state FSM: IDLE, HOLD.
REQ-017 IDLE: at most one of req0_ready/req1_ready is high, driven combinationally from the valids and the priority pointer; both are low in HOLD.
REQ-018 Single valid in IDLE: that port gets ready.
REQ-019 Both valid in IDLE: the port not granted last gets ready (round robin); after reset port 0 wins the first tie.
REQ-020 Transfer = valid && ready at a rising edge. On that edge:
- reg_q loads the data; port 0 data is zero-extended to 32 bits.
- reg_src takes the port index.
- reg_upd goes to 1.
- The priority pointer records the port.
- That port's write counter increments, wrapping modulo 2^CNT_W.
- FSM goes to HOLD with the hold counter set to HOLD_CYC-1.
REQ-021 reg_upd is high for exactly the first cycle of HOLD, otherwise low.
REQ-022 HOLD decrements the hold counter each edge; on the edge where it equals 0 the FSM returns to IDLE, so HOLD lasts exactly HOLD_CYC cycles.
REQ-023 Throughput: at most one transfer per HOLD_CYC+1 cycles; a transfer in cycle T allows the next at T+HOLD_CYC+1.
REQ-024 Valid may drop without a transfer; no state changes when no transfer occurs in IDLE.
REQ-025 Valids asserted during HOLD are not lost by the block; they are served in IDLE only if still high (requesters hold valid until ready).
REQ-026 reg_q, reg_src, the counters and the pointer change only on a transfer or on reset.

Reset
REQ-027 While resetn=1, immediately and independent of clk:
- reg_q=0, reg_src=0, reg_upd=0, busy=0.
- wr_cnt0=0, wr_cnt1=0.
- Hold counter=0, FSM=IDLE, pointer=port 1 granted last (so port 0 wins the first tie).
REQ-028 Reset asserted mid-HOLD aborts the hold. After release the FSM is in IDLE, and the outputs hold their REQ-027 values until the first transfer.
REQ-029 No transfer is accepted while resetn=1 (both readys low).

Verification
REQ-030 Reset check: assert resetn=1 for 7 cycles with random valids -> all outputs 0, no ready; release -> outputs stay 0 until the first transfer.
REQ-031 Port 0 single write: req0_valid=1, req0_data=9'h1A5 in IDLE.
- Next cycle: reg_q=32'h000001A5, reg_src=0, reg_upd=1, busy=1, wr_cnt0=1.
- busy=1 for exactly 2 cycles (HOLD_CYC=2).
REQ-032 Tie: both valids held high, req1_data=32'hDEADBEEF, req0_data=9'h055.
- Grants alternate 0,1,0,1 every 3 cycles.
- reg_q sequence: 00000055, DEADBEEF, 00000055, DEADBEEF.
REQ-033 Back-to-back: req1_valid held high for 10 transfers with random data.
- reg_upd pulses every 3rd cycle.
- wr_cnt1=10; each reg_q value matches the data sent.
REQ-034 Mid-hold reset: reset in the second HOLD cycle after a port 1 write.
- Immediately: reg_q=0, busy=0, wr_cnt1=0.
- After release, req0 is granted on the first tie.
REQ-035 Counter wrap: 256 port 0 transfers with CNT_W=8 -> wr_cnt0 returns to 0; wr_cnt1 unchanged.

Source files
------------

// File: rtl/shared_reg_arb.sv
`default_nettype none
// ============================================================================
// Module   : shared_reg_arb
// Brief    : Two-port round-robin arbiter writing a shared 32-bit register,
//            followed by a fixed hold window after every update.
// Revision : 1.0 - initial release
// ============================================================================
module shared_reg_arb #(
    parameter int HOLD_CYC = 2,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req0_valid,
    input  logic [8:0]       req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [31:0]      req1_data,
    output logic             req1_ready,
    output logic [31:0]      reg_q,
    output logic             reg_src,
    output logic             reg_upd,
    output logic             busy,
    output logic [CNT_W-1:0] wr_cnt0,
    output logic [CNT_W-1:0] wr_cnt1
);

    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_HOLD   = 1'b1;
    localparam logic [3:0] c_HOLD_LOAD = 4'(HOLD_CYC - 1);

    logic [0:0]       r_state;
    logic [3:0]       r_hold_cnt;
    logic             r_last;
    logic [31:0]      r_q;
    logic             r_src;
    logic             r_upd;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    logic             w_idle;
    logic             w_xfer0;
    logic             w_xfer1;
    logic             w_xfer;
    logic [31:0]      w_wdata;

    // On a tie the port that was not granted last wins (r_last=1 means port 1).
    // Reset gating keeps both readys low while reset is held.
    assign w_idle     = (r_state == c_ST_IDLE) && !resetn;
    assign req0_ready = w_idle && req0_valid && (!req1_valid || r_last);
    assign req1_ready = w_idle && req1_valid && (!req0_valid || !r_last);

    assign w_xfer0 = req0_valid && req0_ready;
    assign w_xfer1 = req1_valid && req1_ready;
    assign w_xfer  = w_xfer0 || w_xfer1;
    assign w_wdata = w_xfer1 ? req1_data : {23'd0, req0_data};

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_state    <= c_ST_IDLE;
            r_hold_cnt <= 4'd0;
            r_last     <= 1'b1;
            r_q        <= 32'd0;
            r_src      <= 1'b0;
            r_upd      <= 1'b0;
            r_cnt0     <= '0;
            r_cnt1     <= '0;
        end else begin
            r_upd <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_xfer) begin
                        r_q        <= w_wdata;
                        r_src      <= w_xfer1;
                        r_last     <= w_xfer1;
                        r_upd      <= 1'b1;
                        r_state    <= c_ST_HOLD;
                        r_hold_cnt <= c_HOLD_LOAD;
                        if (w_xfer1) begin
                            r_cnt1 <= r_cnt1 + 1'b1;
                        end else begin
                            r_cnt0 <= r_cnt0 + 1'b1;
                        end
                    end
                end
                c_ST_HOLD: begin
                    if (r_hold_cnt == 4'd0) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign reg_q   = r_q;
    assign reg_src = r_src;
    assign reg_upd = r_upd;
    assign busy    = (r_state == c_ST_HOLD);
    assign wr_cnt0 = r_cnt0;
    assign wr_cnt1 = r_cnt1;

endmodule
`default_nettype wire

// File: tb/tb_shared_reg_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_shared_reg_arb
// Brief    : Directed self-checking bench for shared_reg_arb (HOLD_CYC=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_shared_reg_arb;

    logic        clk;
    logic        resetn;
    logic        req0_valid;
    logic [8:0]  req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic [31:0] reg_q;
    logic        reg_src;
    logic        reg_upd;
    logic        busy;
    logic [7:0]  wr_cnt0;
    logic [7:0]  wr_cnt1;

    int n_chk;
    int n_fail;

    shared_reg_arb #(.HOLD_CYC(2), .CNT_W(8)) u_dut (
        .clk        (clk),
        .resetn     (resetn),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .reg_q      (reg_q),
        .reg_src    (reg_src),
        .reg_upd    (reg_upd),
        .busy       (busy),
        .wr_cnt0    (wr_cnt0),
        .wr_cnt1    (wr_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_q"},    reg_q, 32'd0);
        chk({tag, "_src"},  {31'd0, reg_src}, 32'd0);
        chk({tag, "_upd"},  {31'd0, reg_upd}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_c0"},   {24'd0, wr_cnt0}, 32'd0);
        chk({tag, "_c1"},   {24'd0, wr_cnt1}, 32'd0);
    endtask

    task automatic do_reset();
        resetn     = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        step();
        resetn = 1'b0;
        step();
    endtask

    logic [31:0] data_q[10];
    logic        exp_g;

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        resetn     = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data  = 9'd0;
        req1_data  = 32'd0;

        // Reset held 7 cycles with random valids
        for (int i = 0; i < 7; i++) begin
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req0_data  = 9'($urandom);
            req1_data  = $urandom;
            #1;
            chk("rst_rdy0", {31'd0, req0_ready}, 32'd0);
            chk("rst_rdy1", {31'd0, req1_ready}, 32'd0);
            step();
        end
        chk_zero("rst");
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resetn     = 1'b0;
        step();
        step();
        chk_zero("post_rst");

        // Port 0 single write
        req0_valid = 1'b1;
        req0_data  = 9'h1A5;
        #1;
        chk("p0_rdy", {31'd0, req0_ready}, 32'd1);
        step();
        req0_valid = 1'b0;
        chk("p0_q",    reg_q, 32'h0000_01A5);
        chk("p0_src",  {31'd0, reg_src}, 32'd0);
        chk("p0_upd",  {31'd0, reg_upd}, 32'd1);
        chk("p0_busy", {31'd0, busy}, 32'd1);
        chk("p0_c0",   {24'd0, wr_cnt0}, 32'd1);
        step();
        chk("p0_busy2", {31'd0, busy}, 32'd1);
        chk("p0_upd2",  {31'd0, reg_upd}, 32'd0);
        step();
        chk("p0_busy3", {31'd0, busy}, 32'd0);

        // Tie: grants alternate starting with port 0 after reset
        do_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = 9'h055;
        req1_data  = 32'hDEAD_BEEF;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 1);
            #1;
            chk("tie_rdy0", {31'd0, req0_ready}, {31'd0, !exp_g});
            chk("tie_rdy1", {31'd0, req1_ready}, {31'd0, exp_g});
            step();
            chk("tie_q",   reg_q, exp_g ? 32'hDEAD_BEEF : 32'h0000_0055);
            chk("tie_src", {31'd0, reg_src}, {31'd0, exp_g});
            chk("tie_hold_rdy", {30'd0, req0_ready, req1_ready}, 32'd0);
            step();
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Back-to-back port 1 writes
        do_reset();
        for (int k = 0; k < 10; k++) data_q[k] = $urandom;
        req1_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            req1_data = data_q[k];
            #1;
            chk("b2b_rdy", {31'd0, req1_ready}, 32'd1);
            step();
            req1_data = 32'hFFFF_FFFF;
            chk("b2b_q",   reg_q, data_q[k]);
            chk("b2b_upd", {31'd0, reg_upd}, 32'd1);
            step();
            chk("b2b_upd_h", {31'd0, reg_upd}, 32'd0);
            step();
            chk("b2b_upd_i", {31'd0, reg_upd}, 32'd0);
        end
        req1_valid = 1'b0;
        chk("b2b_c1", {24'd0, wr_cnt1}, 32'd10);
        chk("b2b_c0", {24'd0, wr_cnt0}, 32'd0);

        // Mid-hold reset after a port 1 write
        step();
        req1_valid = 1'b1;
        req1_data  = 32'h1234_5678;
        step();
        req1_valid = 1'b0;
        chk("mh_src", {31'd0, reg_src}, 32'd1);
        step();
        chk("mh_busy_pre", {31'd0, busy}, 32'd1);
        resetn = 1'b1;
        #1;
        chk("mh_q",    reg_q, 32'd0);
        chk("mh_busy", {31'd0, busy}, 32'd0);
        chk("mh_c1",   {24'd0, wr_cnt1}, 32'd0);
        step();
        resetn     = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_data  = 9'h0AA;
        req1_data  = 32'h0BAD_F00D;
        #1;
        chk("mh_tie_rdy0", {31'd0, req0_ready}, 32'd1);
        chk("mh_tie_rdy1", {31'd0, req1_ready}, 32'd0);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("mh_tie_q", reg_q, 32'h0000_00AA);

        // Counter wrap: 256 port 0 transfers
        do_reset();
        req0_valid = 1'b1;
        for (int k = 0; k < 256; k++) begin
            req0_data = 9'(k);
            step();
            step();
            step();
            if (k == 254) chk("wrap_c0_255", {24'd0, wr_cnt0}, 32'd255);
        end
        req0_valid = 1'b0;
        chk("wrap_c0", {24'd0, wr_cnt0}, 32'd0);
        chk("wrap_c1", {24'd0, wr_cnt1}, 32'd0);
        chk("wrap_q",  reg_q, 32'h0000_00FF);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
